// File: rtl/mem_stage_lsu.sv
// M-stage load/store unit: bus req/ack handshake, store lanes, load extension, timeout watchdog.
// Latency: IDLE + N REQ cycles + DONE (3 cycles min); StallM holds the pipe until DONE. Optional macro: MISALIGN_TRAP_EN.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadData,
    output logic        StallM,
    output logic        dreq,
    output logic        dwe,
    output logic [31:0] daddr,
    output logic [3:0]  dbe,
    output logic [31:0] dwdata,
    input  logic        dack,
    input  logic [31:0] drdata,
    output logic        bus_err,
    output logic        misalign_err
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    localparam logic [15:0] TIMER_MAX = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] daddr_q, daddr_d;
    logic [31:0] dwdata_q, dwdata_d;
    logic [3:0]  dbe_q, dbe_d;
    logic        dwe_q, dwe_d;
    logic        load_q, load_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  a_q, a_d;
    logic        bus_err_q, bus_err_d;

    logic        op_vld;
    logic [1:0]  a_in;
    logic [3:0]  be_in;
    logic [31:0] wd_in;
    logic [31:0] rd_shift;
    logic [15:0] rd_half;
    logic [31:0] ld_ext;
    logic        misal_in;

    assign op_vld = MemReadM | MemWriteM;
    assign a_in   = ALUResultM[1:0];

    // Size comes from funct3[1:0]; encodings 10/11 both behave as a full word.
    always_comb begin
        be_in = 4'b1111;
        wd_in = WriteDataM;
        case (funct3M[1:0])
            2'b00: begin
                be_in = 4'b0001 << a_in;
                wd_in = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                be_in = a_in[1] ? 4'b1100 : 4'b0011;
                wd_in = {2{WriteDataM[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_shift = drdata >> {a_q, 3'b000};
    assign rd_half  = a_q[1] ? drdata[31:16] : drdata[15:0];

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_ext = {{16{rd_half[15]}}, rd_half};
            3'b100:  ld_ext = {24'h0, rd_shift[7:0]};
            3'b101:  ld_ext = {16'h0, rd_half};
            default: ld_ext = drdata;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    logic mis_err_q, mis_err_d;

    always_comb begin
        case (funct3M[1:0])
            2'b00:   misal_in = 1'b0;
            2'b01:   misal_in = a_in[0];
            default: misal_in = (a_in != 2'b00);
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) mis_err_q <= 1'b0;
        else        mis_err_q <= mis_err_d;
    end

    assign mis_err_d    = (state_q == IDLE) && op_vld && misal_in;
    assign misalign_err = mis_err_q;
`else
    assign misal_in     = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        rdata_d   = rdata_q;
        daddr_d   = daddr_q;
        dwdata_d  = dwdata_q;
        dbe_d     = dbe_q;
        dwe_d     = dwe_q;
        load_d    = load_q;
        f3_d      = f3_q;
        a_d       = a_q;
        bus_err_d = 1'b0;
        StallM    = 1'b0;
        case (state_q)
            IDLE: begin
                if (op_vld) begin
                    StallM = 1'b1;
                    if (misal_in) begin
                        state_d = DONE;
                        if (MemReadM) rdata_d = 32'h0;
                    end else begin
                        state_d  = REQ;
                        daddr_d  = {ALUResultM[31:2], 2'b00};
                        dbe_d    = be_in;
                        dwdata_d = wd_in;
                        dwe_d    = MemWriteM;
                        load_d   = MemReadM;
                        f3_d     = funct3M;
                        a_d      = a_in;
                    end
                end
            end
            REQ: begin
                StallM = 1'b1;
                // A dack in the final window cycle still wins over the timeout.
                if (dack) begin
                    if (load_q) rdata_d = ld_ext;
                    state_d = DONE;
                    timer_d = 16'h0;
                end else if (timer_q == TIMER_MAX) begin
                    rdata_d   = 32'h0;
                    bus_err_d = 1'b1;
                    state_d   = DONE;
                    timer_d   = 16'h0;
                end else begin
                    timer_d = timer_q + 16'h1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= IDLE;
            timer_q   <= 16'h0;
            rdata_q   <= 32'h0;
            daddr_q   <= 32'h0;
            dwdata_q  <= 32'h0;
            dbe_q     <= 4'h0;
            dwe_q     <= 1'b0;
            load_q    <= 1'b0;
            f3_q      <= 3'h0;
            a_q       <= 2'h0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            rdata_q   <= rdata_d;
            daddr_q   <= daddr_d;
            dwdata_q  <= dwdata_d;
            dbe_q     <= dbe_d;
            dwe_q     <= dwe_d;
            load_q    <= load_d;
            f3_q      <= f3_d;
            a_q       <= a_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign ReadData = rdata_q;
    assign dreq     = (state_q == REQ);
    assign dwe      = dwe_q;
    assign daddr    = daddr_q;
    assign dbe      = dbe_q;
    assign dwdata   = dwdata_q;
    assign bus_err  = bus_err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu with a short watchdog window (TIMEOUT_CYCLES=4).
module tb_mem_stage_lsu;

    logic        clk;
    logic        n_rst;
    logic        MemReadM;
    logic        MemWriteM;
    logic [2:0]  funct3M;
    logic [31:0] ALUResultM;
    logic [31:0] WriteDataM;
    logic [31:0] ReadData;
    logic        StallM;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [3:0]  dbe;
    logic [31:0] dwdata;
    logic        dack;
    logic [31:0] drdata;
    logic        bus_err;
    logic        misalign_err;

    int n_chk  = 0;
    int n_fail = 0;

    mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
        .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .ReadData(ReadData), .StallM(StallM),
        .dreq(dreq), .dwe(dwe), .daddr(daddr), .dbe(dbe), .dwdata(dwdata),
        .dack(dack), .drdata(drdata),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op from IDLE, ack it in REQ cycle ack_at, return positioned in DONE.
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] dat, input int ack_at);
        @(posedge clk); #1;
        MemReadM = rd; MemWriteM = wr; funct3M = f3;
        ALUResultM = addr; WriteDataM = wd; dack = 1'b0;
        #1;
        chk("stall_idle", StallM, 1);
        chk("dreq_idle", dreq, 0);
        @(posedge clk); #1;
        for (int i = 0; i < ack_at; i++) begin
            chk("dreq_wait", dreq, 1);
            @(posedge clk); #1;
        end
        dack = 1'b1; drdata = dat;
        #1;
        chk("dreq_ack", dreq, 1);
        chk("stall_req", StallM, 1);
        @(posedge clk); #1;
        dack = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0;
        #1;
        chk("stall_done", StallM, 0);
        chk("dreq_done", dreq, 0);
        chk("buserr_none", bus_err, 0);
    endtask

    initial begin
        n_rst = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
        ALUResultM = 32'h0; WriteDataM = 32'h0; dack = 1'b0; drdata = 32'h0;
        #12;
        chk("rst_rdata", ReadData, 32'h0);
        chk("rst_dreq", dreq, 0);
        chk("rst_stall", StallM, 0);
        chk("rst_daddr", daddr, 32'h0);
        chk("rst_dbe", {28'h0, dbe}, 32'h0);
        chk("rst_dwdata", dwdata, 32'h0);
        chk("rst_buserr", bus_err, 0);
        chk("rst_misal", misalign_err, 0);
        @(negedge clk); n_rst = 1'b1;

        access(1, 0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEAD_BEEF, 0);
        chk("lw_rdata", ReadData, 32'hDEAD_BEEF);
        chk("lw_daddr", daddr, 32'h0000_0100);
        chk("lw_dbe", {28'h0, dbe}, 32'hF);
        chk("lw_dwe", dwe, 0);
        @(posedge clk); #2;
        chk("idle_after_stall", StallM, 0);

        access(1, 0, 3'b000, 32'h0000_0103, 32'h0, 32'h80FF_0000, 0);
        chk("lb_rdata", ReadData, 32'hFFFF_FF80);
        chk("lb_daddr", daddr, 32'h0000_0100);
        chk("lb_dbe", {28'h0, dbe}, 32'h8);

        access(1, 0, 3'b100, 32'h0000_0103, 32'h0, 32'h80FF_0000, 1);
        chk("lbu_rdata", ReadData, 32'h0000_0080);

        access(1, 0, 3'b001, 32'h0000_0102, 32'h0, 32'h80FF_0000, 0);
        chk("lh_rdata", ReadData, 32'hFFFF_80FF);
        chk("lh_dbe", {28'h0, dbe}, 32'hC);

        access(1, 0, 3'b101, 32'h0000_0100, 32'h0, 32'h1234_8001, 0);
        chk("lhu_rdata", ReadData, 32'h0000_8001);

        access(0, 1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 2);
        chk("sh_dbe", {28'h0, dbe}, 32'hC);
        chk("sh_dwdata", dwdata, 32'hABCD_ABCD);
        chk("sh_dwe", dwe, 1);
        chk("sh_daddr", daddr, 32'h0000_0200);
        chk("sh_rdata_kept", ReadData, 32'h0000_8001);

        access(0, 1, 3'b000, 32'h0000_0201, 32'h0000_0055, 32'h0, 0);
        chk("sb_dbe", {28'h0, dbe}, 32'h2);
        chk("sb_dwdata", dwdata, 32'h5555_5555);

        access(0, 1, 3'b010, 32'h0000_0204, 32'h0102_0304, 32'h0, 0);
        chk("sw_dbe", {28'h0, dbe}, 32'hF);
        chk("sw_dwdata", dwdata, 32'h0102_0304);

        // Watchdog: no dack ever
        @(posedge clk); #1;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0300;
        @(posedge clk); #1;
        for (int i = 0; i < 4; i++) begin
            chk("to_dreq", dreq, 1);
            chk("to_buserr_low", bus_err, 0);
            @(posedge clk); #1;
        end
        MemReadM = 1'b0;
        #1;
        chk("to_dreq_done", dreq, 0);
        chk("to_buserr", bus_err, 1);
        chk("to_rdata", ReadData, 32'h0);
        chk("to_stall", StallM, 0);
        @(posedge clk); #2;
        chk("to_buserr_pulse", bus_err, 0);

        // dack in the last window cycle beats the timeout
        access(1, 0, 3'b010, 32'h0000_0304, 32'h0, 32'hCAFE_F00D, 3);
        chk("lastack_rdata", ReadData, 32'hCAFE_F00D);

`ifdef MISALIGN_TRAP_EN
        @(posedge clk); #1;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0101;
        #1;
        chk("mis_stall_idle", StallM, 1);
        chk("mis_dreq_idle", dreq, 0);
        @(posedge clk); #1;
        MemReadM = 1'b0;
        #1;
        chk("mis_dreq", dreq, 0);
        chk("mis_err", misalign_err, 1);
        chk("mis_rdata", ReadData, 32'h0);
        chk("mis_stall", StallM, 0);
        @(posedge clk); #2;
        chk("mis_err_pulse", misalign_err, 0);
`else
        access(1, 0, 3'b001, 32'h0000_0103, 32'h0, 32'h7F00_1234, 0);
        chk("lh_a3_rdata", ReadData, 32'h0000_7F00);
        access(1, 0, 3'b010, 32'h0000_0101, 32'h0, 32'h1122_3344, 0);
        chk("lw_a1_rdata", ReadData, 32'h1122_3344);
        chk("lw_a1_daddr", daddr, 32'h0000_0100);
        chk("lw_a1_misal", misalign_err, 0);
`endif

        // Reset in the middle of a request
        @(posedge clk); #1;
        MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h0000_0400;
        @(posedge clk); #1;
        chk("mid_dreq_before", dreq, 1);
        n_rst = 1'b0; MemReadM = 1'b0;
        #1;
        chk("mid_dreq", dreq, 0);
        chk("mid_stall", StallM, 0);
        chk("mid_rdata", ReadData, 32'h0);
        chk("mid_daddr", daddr, 32'h0);
        chk("mid_dbe", {28'h0, dbe}, 32'h0);
        @(negedge clk); n_rst = 1'b1;

        access(1, 0, 3'b010, 32'h0000_0010, 32'h0, 32'h0BAD_F00D, 0);
        chk("post_rst_rdata", ReadData, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
